// File: rtl/id_reg_file_pkg.sv
// Shared constants and types for the ID-stage register file and its scoreboard.
package id_reg_file_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 2;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [CNT_W-1:0] sb_cnt_t;

  // A register stalls unless its only remaining writer retires this very cycle.
  function automatic logic pending_f(sb_cnt_t cnt, logic retire_hit);
    return cnt != sb_cnt_t'(retire_hit);
  endfunction
endpackage

// File: rtl/id_reg_file_sb_counter.sv
// Saturating up/down in-flight writer counter; err pulses when an update saturates.
module sb_counter
  import id_reg_file_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    inc,
  input  logic    dec_a,
  input  logic    dec_b,
  output sb_cnt_t cnt,
  output logic    err
);
  localparam int MAX = (1 << CNT_W) - 1;

  sb_cnt_t cnt_q, cnt_d;
  int      sum;

  always_comb begin
    sum   = int'(cnt_q) + int'(inc) - int'(dec_a) - int'(dec_b);
    cnt_d = cnt_q;
    err   = 1'b0;
    if (sum > MAX) begin
      cnt_d = sb_cnt_t'(MAX);
      err   = 1'b1;
    end else if (sum < 0) begin
      cnt_d = '0;
      err   = 1'b1;
    end else begin
      cnt_d = sb_cnt_t'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/id_reg_file.sv
// Decode-side register file with WB write-through bypass and in-flight writer scoreboard.
// Optional debug read port and pending mask when REGFILE_DEBUG_EN is defined.
module id_reg_file
  import id_reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              squash_valid,
  input  logic [ADDR_W-1:0] squash_rd,
  output logic              rs_pending,
  output logic              rt_pending,
  output logic              sb_overflow
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [ADDR_W-1:0]   debug_addr,
  output logic [DATA_W-1:0]   debug_data,
  output logic [NUM_REGS-1:0] debug_pending_mask
`endif
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  sb_cnt_t           cnt [NUM_REGS];
  logic [NUM_REGS-1:0] err;
  logic              sb_overflow_q, sb_overflow_d;
  logic              wb_hit;

  // Reset dominates, so a WB beat presented alongside rst neither bypasses nor retires.
  assign wb_hit = wb_we && (wb_addr != REG_ZERO) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_hit) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign cnt[0] = '0;
  assign err[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
      sb_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (issue_valid  && (issue_rd  == ADDR_W'(gi))),
        .dec_a (wb_we        && (wb_addr   == ADDR_W'(gi))),
        .dec_b (squash_valid && (squash_rd == ADDR_W'(gi))),
        .cnt   (cnt[gi]),
        .err   (err[gi])
      );
    end
  endgenerate

  assign sb_overflow_d = sb_overflow_q | (|err);

  always_ff @(posedge clk) begin
    if (rst) sb_overflow_q <= 1'b0;
    else     sb_overflow_q <= sb_overflow_d;
  end

  assign sb_overflow = sb_overflow_q;

  assign rs_data = (rs_addr == REG_ZERO)            ? '0      :
                   (wb_hit && (wb_addr == rs_addr)) ? wb_data : regs_q[rs_addr];
  assign rt_data = (rt_addr == REG_ZERO)            ? '0      :
                   (wb_hit && (wb_addr == rt_addr)) ? wb_data : regs_q[rt_addr];

  assign rs_pending = pending_f(cnt[rs_addr], wb_hit && (wb_addr == rs_addr));
  assign rt_pending = pending_f(cnt[rt_addr], wb_hit && (wb_addr == rt_addr));

`ifdef REGFILE_DEBUG_EN
  assign debug_data = (debug_addr == REG_ZERO)            ? '0      :
                      (wb_hit && (wb_addr == debug_addr)) ? wb_data : regs_q[debug_addr];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dbg_mask
      assign debug_pending_mask[gi] = cnt[gi] != '0;
    end
  endgenerate
`endif
endmodule

// File: tb/tb_id_reg_file.sv
// Self-checking bench for id_reg_file: directed scenarios plus randomized traffic vs. a model.
module tb_id_reg_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wb_addr, issue_rd, squash_rd;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_we, issue_valid, squash_valid;
  logic        rs_pending, rt_pending, sb_overflow;
`ifdef REGFILE_DEBUG_EN
  logic [31:0] debug_data;
  logic [31:0] debug_pending_mask;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: architectural register values and writer counts per register.
  logic [31:0] m_reg [32];
  int          m_cnt [32];
  bit          m_ovf;

  always #5 clk = ~clk;

  id_reg_file dut (
    .clk          (clk),
    .rst          (rst),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .squash_valid (squash_valid),
    .squash_rd    (squash_rd),
    .rs_pending   (rs_pending),
    .rt_pending   (rt_pending),
    .sb_overflow  (sb_overflow)
`ifdef REGFILE_DEBUG_EN
    ,
    .debug_addr         (rs_addr),
    .debug_data         (debug_data),
    .debug_pending_mask (debug_pending_mask)
`endif
  );

  task automatic idle();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    squash_valid = 1'b0; squash_rd = '0;
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r] = '0;
        m_cnt[r] = 0;
      end
      m_ovf = 1'b0;
    end else begin
      if (wb_we && wb_addr != 0) m_reg[wb_addr] = wb_data;
      for (int r = 1; r < 32; r++) begin
        int n;
        n = m_cnt[r];
        if (issue_valid  && issue_rd  == r) n++;
        if (wb_we        && wb_addr   == r) n--;
        if (squash_valid && squash_rd == r) n--;
        if (n > 3) begin n = 3; m_ovf = 1'b1; end
        if (n < 0) begin n = 0; m_ovf = 1'b1; end
        m_cnt[r] = n;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); rs_addr = '0; rt_addr = '0;
    rst = 1'b1; tick(); tick();
    rst = 1'b0; #1;
    for (int a = 0; a < 32; a += 7) begin
      rs_addr = 5'(a); rt_addr = 5'(31 - a); #1;
      n_total++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0) $display("FAIL reset_data a=%0d rs=%h rt=%h want 0", a, rs_data, rt_data);
      else n_pass++;
      n_total++;
      if (rs_pending !== 1'b0 || rt_pending !== 1'b0 || sb_overflow !== 1'b0)
        $display("FAIL reset_flags a=%0d rsp=%b rtp=%b ovf=%b want 000", a, rs_pending, rt_pending, sb_overflow);
      else n_pass++;
    end
    $display("reset: checked idle reads");
  endtask

  task automatic test_write_bypass();
    idle(); rs_addr = 5'd5;
    issue_valid = 1'b1; issue_rd = 5'd5; tick();
    idle(); wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; #1;
    n_total++;
    if (rs_data !== 32'hDEADBEEF) $display("FAIL bypass_data got %h want deadbeef", rs_data);
    else n_pass++;
    n_total++;
    if (rs_pending !== 1'b0) $display("FAIL bypass_pending got %b want 0", rs_pending);
    else n_pass++;
    tick(); idle(); #1;
    n_total++;
    if (rs_data !== 32'hDEADBEEF) $display("FAIL stored_data got %h want deadbeef", rs_data);
    else n_pass++;
    $display("write_bypass: r5 <= deadbeef");
  endtask

  task automatic test_reg_zero();
    idle(); rs_addr = 5'd0;
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    issue_valid = 1'b1; issue_rd = 5'd0; #1;
    n_total++;
    if (rs_data !== 32'h0) $display("FAIL zero_bypass got %h want 0", rs_data);
    else n_pass++;
    tick(); idle(); #1;
    n_total++;
    if (rs_data !== 32'h0 || rs_pending !== 1'b0 || sb_overflow !== 1'b0)
      $display("FAIL zero_after data=%h pend=%b ovf=%b want 0/0/0", rs_data, rs_pending, sb_overflow);
    else n_pass++;
    $display("reg_zero: writes/issues to r0 ignored");
  endtask

  task automatic test_retire();
    idle(); rt_addr = 5'd8;
    issue_valid = 1'b1; issue_rd = 5'd8; tick(); tick();
    idle(); #1;
    n_total++;
    if (rt_pending !== 1'b1) $display("FAIL retire_two got %b want 1", rt_pending);
    else n_pass++;
    tick();
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000_1111; #1;
    n_total++;
    if (rt_pending !== 1'b1) $display("FAIL retire_first got %b want 1", rt_pending);
    else n_pass++;
    tick();
    wb_data = 32'h0000_2222; #1;
    n_total++;
    if (rt_pending !== 1'b0 || rt_data !== 32'h0000_2222)
      $display("FAIL retire_last pend=%b data=%h want 0/00002222", rt_pending, rt_data);
    else n_pass++;
    tick(); idle(); #1;
    n_total++;
    if (rt_pending !== 1'b0 || rt_data !== 32'h0000_2222 || sb_overflow !== 1'b0)
      $display("FAIL retire_after pend=%b data=%h ovf=%b want 0/00002222/0", rt_pending, rt_data, sb_overflow);
    else n_pass++;
    $display("retire: r8 two writers retired");
  endtask

  task automatic test_simultaneous();
    idle(); rt_addr = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd9; tick(); tick();
    squash_valid = 1'b1; squash_rd = 5'd9;
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hCAFE_0009; tick();
    idle(); #1;
    n_total++;
    if (rt_pending !== 1'b1 || sb_overflow !== 1'b0)
      $display("FAIL simul_cnt1 pend=%b ovf=%b want 1/0", rt_pending, sb_overflow);
    else n_pass++;
    squash_valid = 1'b1; squash_rd = 5'd9; tick(); idle(); #1;
    n_total++;
    if (rt_pending !== 1'b0 || sb_overflow !== 1'b0)
      $display("FAIL simul_cnt0 pend=%b ovf=%b want 0/0", rt_pending, sb_overflow);
    else n_pass++;
    $display("simultaneous: r9 issue+squash+wb");
  endtask

  task automatic test_overflow();
    idle(); rs_addr = 5'd3;
    issue_valid = 1'b1; issue_rd = 5'd3;
    for (int k = 0; k < 4; k++) tick();
    idle(); #1;
    n_total++;
    if (rs_pending !== 1'b1 || sb_overflow !== 1'b1)
      $display("FAIL ovf_set pend=%b ovf=%b want 1/1", rs_pending, sb_overflow);
    else n_pass++;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    tick(); tick(); idle(); #1;
    n_total++;
    if (rs_pending !== 1'b1) $display("FAIL ovf_saturated pend=%b want 1", rs_pending);
    else n_pass++;
    wb_we = 1'b1; wb_addr = 5'd3; tick(); idle(); #1;
    n_total++;
    if (rs_pending !== 1'b0 || sb_overflow !== 1'b1)
      $display("FAIL ovf_sticky pend=%b ovf=%b want 0/1", rs_pending, sb_overflow);
    else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0; #1;
    n_total++;
    if (sb_overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", sb_overflow);
    else n_pass++;
    $display("overflow: r3 saturated, flag sticky until rst");
  endtask

  task automatic test_random();
    logic [31:0] exp_rs, exp_rt;
    logic        exp_rsp, exp_rtp, hit_rs, hit_rt;
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    for (int t = 0; t < 200; t++) begin
      rst          = ($urandom_range(59, 0) == 0);
      rs_addr      = 5'($urandom_range(7, 0));
      rt_addr      = 5'($urandom_range(7, 0));
      issue_valid  = ($urandom_range(2, 0) != 0);
      issue_rd     = 5'($urandom_range(7, 0));
      wb_we        = ($urandom_range(2, 0) == 0);
      wb_addr      = 5'($urandom_range(7, 0));
      wb_data      = $urandom;
      squash_valid = ($urandom_range(5, 0) == 0);
      squash_rd    = 5'($urandom_range(7, 0));
      #1;
      if (!rst) begin
        hit_rs  = wb_we && wb_addr != 0 && wb_addr == rs_addr;
        hit_rt  = wb_we && wb_addr != 0 && wb_addr == rt_addr;
        exp_rs  = (rs_addr == 0) ? 32'h0 : hit_rs ? wb_data : m_reg[rs_addr];
        exp_rt  = (rt_addr == 0) ? 32'h0 : hit_rt ? wb_data : m_reg[rt_addr];
        exp_rsp = (m_cnt[rs_addr] - int'(hit_rs)) != 0;
        exp_rtp = (m_cnt[rt_addr] - int'(hit_rt)) != 0;
        n_total++;
        if (rs_data !== exp_rs || rt_data !== exp_rt)
          $display("FAIL rand_data t=%0d rs=%h/%h rt=%h/%h (got/want)", t, rs_data, exp_rs, rt_data, exp_rt);
        else n_pass++;
        n_total++;
        if (rs_pending !== exp_rsp || rt_pending !== exp_rtp || sb_overflow !== m_ovf)
          $display("FAIL rand_flags t=%0d rsp=%b/%b rtp=%b/%b ovf=%b/%b (got/want)",
                   t, rs_pending, exp_rsp, rt_pending, exp_rtp, sb_overflow, m_ovf);
        else n_pass++;
        $display("rand t=%0d rs=%0d rt=%0d wb=%b:%0d iss=%b:%0d sq=%b:%0d", t, rs_addr, rt_addr,
                 wb_we, wb_addr, issue_valid, issue_rd, squash_valid, squash_rd);
      end else begin
        $display("rand t=%0d reset", t);
      end
      tick();
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    rst = 1'b1; idle(); rs_addr = '0; rt_addr = '0;
    test_reset();
    test_write_bypass();
    test_reg_zero();
    test_retire();
    test_simultaneous();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/id_reg_file.md
Name: id_reg_file

Overview:
- Register file on the decode side of the 5-stage pipeline; the receiving end of the write-back path.
- Accepts the WB-stage write (register write enable, destination, selected write data) and serves two ID-stage read ports, with same-cycle write-through bypass.
- Holds a per-register in-flight write scoreboard. ID uses it to stall reads of registers whose writer has not yet retired.

Parameters:
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.
- CNT_W, 2, width of each scoreboard counter; max 3 in-flight writers per register.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rs_addr  input  ADDR_W  read port A index.
- rt_addr  input  ADDR_W  read port B index.
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- wb_we  input  1  WB write enable (WREG from WB).
- wb_addr  input  ADDR_W  WB destination register.
- wb_data  input  DATA_W  WB write data (mem-or-ALU selected value).
- issue_valid  input  1  ID issues an instruction that will write issue_rd.
- issue_rd  input  ADDR_W  destination of the issuing instruction.
- squash_valid  input  1  an in-flight writer was flushed and will never retire.
- squash_rd  input  ADDR_W  destination of the squashed writer.
- rs_pending  output  1  rs_addr has an unretired writer.
- rt_pending  output  1  rt_addr has an unretired writer.
- sb_overflow  output  1  sticky error flag.

Behaviour:
- Storage: 32 x DATA_W registers; reg[0] reads 0 always, and writes to 0 are ignored.
- Write: on a rising edge with wb_we=1 and wb_addr!=0, reg[wb_addr] <= wb_data.
- Read: combinational, zero latency.
- Bypass: if wb_we=1, wb_addr!=0 and wb_addr equals the read index, the port returns wb_data in the same cycle (write-before-read semantics).
- Scoreboard: cnt[r] is CNT_W bits, next-state per register r!=0:
  - +1 if issue_valid and issue_rd==r;
  - -1 if wb_we and wb_addr==r;
  - -1 if squash_valid and squash_rd==r.
  - All three sources are applied in the same cycle; net delta is in the range -2..+1.
  - cnt[0] is constant 0; events addressed to 0 are ignored.
- Pending: rs_pending = (cnt[rs_addr] - retire_hit(rs_addr)) != 0, where retire_hit=1 if the same-cycle WB write targets that register. A value arriving this cycle via bypass therefore does not stall, unless an older writer still remains.
- Boundaries:
  - Increment at cnt=max: saturate, set sb_overflow.
  - Decrement below 0: hold at 0, set sb_overflow.
  - sb_overflow clears only on rst.
- Reset: all registers <= 0, all counters <= 0, sb_overflow <= 0. rs_data, rt_data, rs_pending and rt_pending all read 0 once reset is applied.
- Reset mid-operation discards every in-flight count; rst dominates all same-cycle events.

Optional Feature:
- Macro: REGFILE_DEBUG_EN.
- Defined:
  - Adds ports debug_addr (input, ADDR_W), debug_data (output, DATA_W) and debug_pending_mask (output, 32 bits, bit r = cnt[r]!=0).
  - debug_data is combinational with the same bypass rule as rs/rt.
- Undefined: these ports and their logic do not exist; core behaviour is identical.

Decomposition:
- Shared package: ADDR_W, DATA_W and REG_ZERO (=0) constants; a typedef for the scoreboard counter.
- One natural sub-module: sb_counter. It is a single saturating up/down counter with inputs inc, dec_a, dec_b and outputs cnt, err. It is instantiated 31 times.

Test Plan:
- Reset then reads -> rst=1 for 2 cycles; any rs/rt address reads 0 with pending=0 and sb_overflow=0.
- Plain write and bypass -> wb_we=1, wb_addr=5, wb_data=0xDEADBEEF; with rs_addr=5 in the same cycle, rs_data=0xDEADBEEF. The next cycle, with wb_we=0, rs_data is still 0xDEADBEEF.
- Register zero -> wb_we=1, wb_addr=0, wb_data=0x1234; rs_data at addr 0 is 0. Issuing issue_rd=0 leaves rs_pending=0.
- Scoreboard retire -> issue r8 at cycles 1 and 2; rt_pending=1. WB retires r8 at cycle 4: rt_pending=1 (one writer left); WB r8 at cycle 5: rt_pending=0 in that cycle via retire_hit.
- Simultaneous events -> cnt[9]=2; in one cycle issue r9, squash r9 and WB r9 -> cnt[9]=1 next cycle, with no overflow.
- Overflow -> four issues to r3 with no retire -> cnt stays 3 and sb_overflow=1. It remains 1 after retires, and clears on rst.
